// File: rtl/led_pkg.sv
// Shared types and constants for the LED line writer: panel geometry,
// control-bus write mask, FSM states, request record and address helper.
package led_pkg;

    localparam int          PANEL_W    = 32;
    localparam logic [3:0]  CTRL_WMASK = 4'b0111;

    localparam logic [23:0] COLOR    = 24'h00ff00;
    localparam logic [23:0] CI_COLOR = 24'hff0000;
    localparam logic [23:0] R_COLOR  = 24'h0000ff;
    localparam logic [23:0] W_COLOR  = 24'hffff00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  line;
        logic [31:0] value;
        logic [23:0] color;
    } req_t;

    // Store line L is drawn as panel column 31-L, pixel px as panel row px.
    function automatic logic [15:0] pixel_addr(input logic [4:0] line, input logic [4:0] px);
        logic [15:0] w_word;
        w_word = ({11'd0, px} << 5) + 16'd31 - {11'd0, line};
        return w_word << 2;
    endfunction

endpackage

// File: rtl/led_line_writer_if.sv
// Request bus from the sequencer and control bus to the LED panel, bundled
// so the writer sees both sides through one port.
interface led_line_writer_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_line;
    logic [31:0] req_value;
    logic [23:0] req_color;

    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic        ctrl_done;

    modport slave (
        input  req_valid, req_line, req_value, req_color, ctrl_done,
        output req_ready, ctrl_wr, ctrl_addr, ctrl_wdat
    );

    modport master (
        output req_valid, req_line, req_value, req_color, ctrl_done,
        input  req_ready, ctrl_wr, ctrl_addr, ctrl_wdat
    );

endinterface

// File: rtl/led_line_writer_req_fifo.sv
// Synchronous request FIFO with registered full/empty; the head entry is
// read directly from storage so a pop sees it in the same cycle.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage is left unreset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/led_line_writer.sv
// Expands queued line-update requests into 32 single-pixel panel writes,
// holding each write on the control bus until the panel acknowledges it.
module led_line_writer
    import led_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PANEL_W = 32
) (
    input  logic             clk100,
    input  logic             reset,
    led_line_writer_if.slave bus,
    output logic             line_done,
    output logic             idle
);

    localparam int             PXW     = $clog2(PANEL_W);
    localparam logic [PXW-1:0] LAST_PX = PXW'(PANEL_W - 1);

    state_t         r_state;
    state_t         w_next;
    req_t           r_req;
    req_t           w_head;
    req_t           w_push_data;
    logic [PXW-1:0] r_px;
    logic [3:0]     r_ctrl_wr;
    logic [15:0]    r_ctrl_addr;
    logic [31:0]    r_ctrl_wdat;
    logic           r_line_done;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_issue;
    logic           w_ack;
    logic           w_last;

    // Ready comes from registered occupancy, so a full FIFO refuses even when popping.
    assign bus.req_ready = !w_full;
    assign w_push        = bus.req_valid && !w_full;
    assign w_push_data   = {bus.req_line, bus.req_value, bus.req_color};

    assign bus.ctrl_wr   = r_ctrl_wr;
    assign bus.ctrl_addr = r_ctrl_addr;
    assign bus.ctrl_wdat = r_ctrl_wdat;
    assign line_done     = r_line_done;
    assign idle          = w_empty && (r_state == ST_IDLE);

    req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk100),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FSM state register.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle action decode; ctrl_done only matters in WAIT.
    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_issue = 1'b0;
        w_ack   = 1'b0;
        w_last  = (r_px == LAST_PX);
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_SETUP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_issue = 1'b1;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.ctrl_done) begin
                    w_ack  = 1'b1;
                    w_next = w_last ? ST_IDLE : ST_SETUP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Working registers, pixel counter and the registered panel-bus outputs.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_req       <= '0;
            r_px        <= '0;
            r_ctrl_wr   <= 4'b0000;
            r_ctrl_addr <= 16'h0000;
            r_ctrl_wdat <= 32'h0000_0000;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= w_ack && w_last;
            if (w_pop) begin
                r_req <= w_head;
                r_px  <= '0;
            end else if (w_ack && !w_last) begin
                r_px <= r_px + 1'b1;
            end
            if (w_issue) begin
                r_ctrl_addr <= pixel_addr(r_req.line, r_px);
                r_ctrl_wdat <= r_req.value[r_px] ? {8'h00, r_req.color} : 32'h0000_0000;
                r_ctrl_wr   <= CTRL_WMASK;
            end else if (w_ack) begin
                r_ctrl_wr <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_led_line_writer.sv
// Directed bench for led_line_writer: expected pixel writes are queued per
// request and compared, in order, against writes seen on the panel bus.
module tb_led_line_writer;
    import led_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic [3:0]  wr;
    } wr_t;

    logic clk100 = 1'b0;
    logic reset;
    logic line_done;
    logic idle;

    led_line_writer_if bus();

    led_line_writer #(.DEPTH(4), .PANEL_W(32)) dut (
        .clk100    (clk100),
        .reset     (reset),
        .bus       (bus.slave),
        .line_done (line_done),
        .idle      (idle)
    );

    always #5 clk100 = ~clk100;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    int         n_cmp     = 0;
    int         n_fail    = 0;
    int         wr_cnt    = 0;
    int         ld_cnt    = 0;
    int         hold_err  = 0;
    logic [3:0]  prev_wr   = 4'd0;
    logic [15:0] prev_addr = 16'd0;
    logic [31:0] prev_wdat = 32'd0;

    // Bus monitor: a new write is a rise of ctrl_wr; while it stays high nothing may move.
    always @(negedge clk100) begin
        if (bus.ctrl_wr != 4'd0 && prev_wr == 4'd0) begin
            obs_q.push_back('{bus.ctrl_addr, bus.ctrl_wdat, bus.ctrl_wr});
            wr_cnt <= wr_cnt + 1;
        end else if (bus.ctrl_wr != 4'd0 && (bus.ctrl_wr != prev_wr ||
                     bus.ctrl_addr != prev_addr || bus.ctrl_wdat != prev_wdat)) begin
            hold_err <= hold_err + 1;
        end
        if (line_done) begin
            ld_cnt <= ld_cnt + 1;
        end
        prev_wr   <= bus.ctrl_wr;
        prev_addr <= bus.ctrl_addr;
        prev_wdat <= bus.ctrl_wdat;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_line(input logic [4:0] line, input logic [31:0] value, input logic [23:0] color);
        wr_t e;
        for (int px = 0; px < 32; px++) begin
            e.addr = 16'((px * 32 + 31 - int'(line)) * 4);
            e.wdat = value[px] ? {8'h00, color} : 32'h0;
            e.wr   = 4'b0111;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        wr_t o;
        wr_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 64'(o.addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(o.addr), 64'(e.addr));
                check("wr_wdat", 64'(o.wdat), 64'(e.wdat));
                check("wr_mask", 64'(o.wr), 64'(e.wr));
            end
        end
    endtask

    // Present one request and hold it until accepted; returns at negedge+1.
    task automatic push(input logic [4:0] line, input logic [31:0] value,
                        input logic [23:0] color, output int stalls);
        stalls        = 0;
        bus.req_valid = 1'b1;
        bus.req_line  = line;
        bus.req_value = value;
        bus.req_color = color;
        while (!bus.req_ready && stalls < 400) begin
            @(negedge clk100);
            #1;
            stalls++;
        end
        check("push_accepted", 64'(stalls < 400), 64'd1);
        expect_line(line, value, color);
        @(posedge clk100);
        @(negedge clk100);
        #1;
    endtask

    // Panel model: ack after `delay` WAIT cycles; with spur the ack is stretched
    // through the following SETUP/IDLE cycle. Stops on a line count or write count.
    task automatic serve(input int delay, input bit spur, input int n_lines,
                         input int wr_stop, input int budget);
        int l0;
        int cyc;
        int wcnt;
        bit held;
        bit stop;
        l0   = ld_cnt;
        cyc  = 0;
        wcnt = 0;
        held = 1'b0;
        stop = 1'b0;
        while (!stop && cyc < budget) begin
            @(negedge clk100);
            #1;
            cyc++;
            drain();
            if (bus.ctrl_done) begin
                if (spur && !held) begin
                    held = 1'b1;
                end else begin
                    bus.ctrl_done = 1'b0;
                    held          = 1'b0;
                    wcnt          = 0;
                end
            end else if ((ld_cnt - l0) >= n_lines || wr_cnt >= wr_stop) begin
                stop = 1'b1;
            end else if (bus.ctrl_wr != 4'd0) begin
                wcnt++;
                if (wcnt >= delay) begin
                    bus.ctrl_done = 1'b1;
                end
            end
        end
        bus.ctrl_done = 1'b0;
        check("serve_in_budget", 64'(stop), 64'd1);
    endtask

    initial begin
        int st;
        int stalls;
        int l0;
        int w0;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_line  = 5'd0;
        bus.req_value = 32'd0;
        bus.req_color = 24'd0;
        bus.ctrl_done = 1'b0;
        repeat (3) @(negedge clk100);
        #1;
        check("rst_wr", 64'(bus.ctrl_wr), 64'd0);
        check("rst_addr", 64'(bus.ctrl_addr), 64'd0);
        check("rst_wdat", 64'(bus.ctrl_wdat), 64'd0);
        check("rst_line_done", 64'(line_done), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_idle", 64'(idle), 64'd1);
        reset = 1'b0;

        // Single set bit on line 0, one-cycle acknowledge.
        l0 = ld_cnt;
        w0 = wr_cnt;
        push(5'd0, 32'h0000_0001, COLOR, st);
        bus.req_valid = 1'b0;
        check("t1_idle_after_accept", 64'(idle), 64'd0);
        @(negedge clk100);
        #1;
        check("t1_wr_low_after_n1", 64'(bus.ctrl_wr), 64'd0);
        @(negedge clk100);
        #1;
        check("t1_wr_high_after_n2", 64'(bus.ctrl_wr), 64'(4'b0111));
        serve(1, 1'b0, 1, 1 << 30, 200);
        check("t1_writes", 64'(wr_cnt - w0), 64'd32);
        check("t1_line_done", 64'(ld_cnt - l0), 64'd1);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t1_idle", 64'(idle), 64'd1);

        // Full line on line 31 with a slow panel.
        l0 = ld_cnt;
        w0 = wr_cnt;
        push(5'd31, 32'hFFFF_FFFF, CI_COLOR, st);
        bus.req_valid = 1'b0;
        serve(5, 1'b0, 1, 1 << 30, 400);
        check("t2_writes", 64'(wr_cnt - w0), 64'd32);
        check("t2_line_done", 64'(ld_cnt - l0), 64'd1);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t2_hold_stable", 64'(hold_err), 64'd0);

        // Five back-to-back requests against a stalled panel fill the FIFO.
        l0     = ld_cnt;
        w0     = wr_cnt;
        stalls = 0;
        push(5'd1, 32'h8000_0001, COLOR, st);    stalls += st;
        push(5'd2, 32'h0F0F_0F0F, R_COLOR, st);  stalls += st;
        push(5'd3, 32'h1234_5678, W_COLOR, st);  stalls += st;
        push(5'd4, 32'hFFFF_0000, CI_COLOR, st); stalls += st;
        push(5'd5, 32'h0000_FFFF, 24'h123456, st); stalls += st;
        bus.req_valid = 1'b0;
        check("t3_no_stall", 64'(stalls), 64'd0);
        check("t3_ready_low_full", 64'(bus.req_ready), 64'd0);
        @(negedge clk100);
        #1;
        check("t3_ready_stays_low", 64'(bus.req_ready), 64'd0);
        serve(1, 1'b0, 5, 1 << 30, 800);
        check("t3_writes", 64'(wr_cnt - w0), 64'd160);
        check("t3_line_done", 64'(ld_cnt - l0), 64'd5);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t3_ready_back", 64'(bus.req_ready), 64'd1);

        // Reset during pixel 17 with two more lines queued.
        l0 = ld_cnt;
        w0 = wr_cnt;
        push(5'd5, 32'hDEAD_BEEF, COLOR, st);
        push(5'd6, 32'h0000_0003, R_COLOR, st);
        push(5'd7, 32'hC000_0000, W_COLOR, st);
        bus.req_valid = 1'b0;
        serve(1, 1'b0, 99, w0 + 18, 200);
        check("t4_writes_before_reset", 64'(wr_cnt - w0), 64'd18);
        reset = 1'b1;
        @(negedge clk100);
        #1;
        reset = 1'b0;
        check("t4_wr_cleared", 64'(bus.ctrl_wr), 64'd0);
        check("t4_addr_cleared", 64'(bus.ctrl_addr), 64'd0);
        check("t4_wdat_cleared", 64'(bus.ctrl_wdat), 64'd0);
        check("t4_idle", 64'(idle), 64'd1);
        check("t4_ready", 64'(bus.req_ready), 64'd1);
        check("t4_no_line_done_now", 64'(line_done), 64'd0);
        exp_q.delete();
        repeat (6) @(negedge clk100);
        #1;
        drain();
        check("t4_no_line_done", 64'(ld_cnt - l0), 64'd0);
        check("t4_no_more_writes", 64'(wr_cnt - w0), 64'd18);
        w0 = wr_cnt;
        push(5'd9, 32'hA5A5_A5A5, W_COLOR, st);
        bus.req_valid = 1'b0;
        serve(1, 1'b0, 1, 1 << 30, 200);
        check("t4_restart_writes", 64'(wr_cnt - w0), 64'd32);
        check("t4_restart_line_done", 64'(ld_cnt - l0), 64'd1);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Spurious acknowledges in IDLE and SETUP.
        l0 = ld_cnt;
        w0 = wr_cnt;
        bus.ctrl_done = 1'b1;
        repeat (2) @(negedge clk100);
        #1;
        bus.ctrl_done = 1'b0;
        check("t5_idle_spur_wr", 64'(bus.ctrl_wr), 64'd0);
        check("t5_idle_spur_idle", 64'(idle), 64'd1);
        push(5'd3, 32'h8000_0001, R_COLOR, st);
        bus.req_valid = 1'b0;
        serve(2, 1'b1, 1, 1 << 30, 400);
        check("t5_writes", 64'(wr_cnt - w0), 64'd32);
        check("t5_line_done", 64'(ld_cnt - l0), 64'd1);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        check("hold_stable_all", 64'(hold_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
